uart_tx_arbiter: RTL
====================

// Module: uart_tx_arbiter
// PURPOSE
//  Shares one 8-bit UART transmitter (16x-oversampled, parity, 1 stop) among NUM_REQ
//  requesters. Round-robin arbitration on byte boundaries; sequences tx_start/tx_busy
//  handshake; returns per-requester ack when byte is handed to transmitter.
//  Sits between status/echo sources (e.g. rx-byte echo path) and the uart_tx datapath.
// PARAMETERS
//  NUM_REQ   4    number of requesters (2..8)
//  BUSY_TO   15   cycles to wait for tx_busy rise after tx_start before abandoning
// PORTS
//  clk        in   1          system clock
//  rst_n      in   1          async active-low reset
//  req        in   NUM_REQ    per-requester byte request, level, held until ack
//  req_data   in   8*NUM_REQ  byte for requester i at [8*i+7:8*i], stable while req[i]
//  ack        out  NUM_REQ    one-cycle pulse: byte of requester i accepted
//  grant_id   out  3          index of requester currently owning transmitter
//  tx_start   out  1          one-cycle pulse to transmitter, tx_data valid same cycle
//  tx_data    out  8          byte to transmit
//  tx_busy    in   1          transmitter busy; rises <=BUSY_TO cycles after tx_start
//  tx_timeout out  1          sticky: transmitter never acknowledged a start
// BEHAVIOUR
//  Reset: state=IDLE, ack=0, tx_start=0, tx_data=8'h00, grant_id=0, rr pointer=0
//   (requester 0 highest priority), tx_timeout=0. Reset mid-byte aborts; no ack issued.
//  FSM: IDLE -> LOAD -> WAIT_HI -> WAIT_LO -> IDLE.
//   IDLE: if any req and tx_busy=0 -> pick winner, latch grant_id, go LOAD.
//         tx_busy=1 in IDLE (foreign start) -> stay IDLE.
//   LOAD: tx_data<=req_data[winner]; tx_start=1 and ack[winner]=1 for exactly this
//         cycle; rr pointer <= winner+1 (wraps NUM_REQ-1 -> 0); go WAIT_HI.
//   WAIT_HI: wait tx_busy=1 -> WAIT_LO. Counter reaching BUSY_TO -> set tx_timeout,
//         go IDLE (byte lost, ack already given).
//   WAIT_LO: wait tx_busy=0 -> IDLE. No timeout.
//  Arbitration: first asserted req scanning from pointer upward, modulo NUM_REQ.
//   Latency req->tx_start: 2 cycles when idle (arb cycle + LOAD).
//  Requester dropping req before LOAD: re-arbitrate in LOAD using current req; if
//   none asserted, return to IDLE, no tx_start, no ack, pointer unchanged.
//  Requester may raise next req in cycle after ack; served after other pending reqs.
//  Simultaneous req from all: strict rotation, each served once per NUM_REQ bytes.
//  At most one ack bit high per cycle; ack only coincident with tx_start.
//  tx_data holds last byte until next LOAD. tx_timeout cleared only by reset.
// CONFIGURATION
//  UART_ARB_TAG_EN defined: each granted byte preceded by tag byte 8'hA0|grant_id.
//   FSM adds TAG_LOAD/TAG_HI/TAG_LO before LOAD (same handshake, same timeout);
//   ack still pulses only with the data-byte tx_start; grant held across tag+data.
//   Timeout during tag: go IDLE, no data sent, no ack, pointer unchanged.
//  Not defined: untagged, one byte per grant, as above.
// STRUCTURE
//  Package uart_pkg: state encoding localparams, UART_TAG_BASE=8'hA0, BYTE_W=8,
//   timeout counter width (4 bits for BUSY_TO<=15).
//  Sub-module rr_arb (req, pointer -> one-hot grant + index), combinational,
//   reused by future rx dispatch block. FSM, latches, counter in this module.
// TESTING
//  1 single req[2], data 8'h5A, tx_busy model 1 cyc after start, 160 cyc busy ->
//    tx_start 2 cyc after req, tx_data=5A, ack[2] with tx_start, pointer=3.
//  2 req=4'b1111, data 11/22/33/44, hold after ack -> bytes 11,22,33,44,11 in order,
//    no tx_start while tx_busy=1.
//  3 tx_busy tied 0 -> tx_timeout=1 after 15 WAIT_HI cycles, FSM in IDLE, next req
//    still served.
//  4 req[1] pulsed 1 cycle only (drops before LOAD) -> no tx_start, no ack[1].
//  5 rst_n low during WAIT_LO -> all outputs to reset values immediately; after release
//    pending req[0] served first.
//  6 UART_ARB_TAG_EN, req[3] data 8'h7E -> tx_data A3 then 7E, single ack[3] on 7E.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit arbitration slice.
package uart_pkg;

    localparam int BYTE_W   = 8;
    localparam int TO_CNT_W = 4;
    localparam logic [BYTE_W-1:0] UART_TAG_BASE = 8'hA0;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_LOAD     = 3'd1,
        ST_WAIT_HI  = 3'd2,
        ST_WAIT_LO  = 3'd3,
        ST_TAG_LOAD = 3'd4,
        ST_TAG_HI   = 3'd5,
        ST_TAG_LO   = 3'd6
    } arb_state_t;

endpackage

// File: rtl/uart_tx_arbiter_rr_arb.sv
// Combinational round-robin picker: first asserted request at or above ptr,
// wrapping modulo NUM_REQ. Returns one-hot grant, its index and a valid flag.
module rr_arb #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [2:0]         ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [2:0]         idx,
    output logic               vld
);

    localparam logic [3:0] NR = 4'(NUM_REQ);

    logic [7:0] req_ext;
    logic [3:0] sum;
    logic [2:0] cand;

    assign req_ext = 8'(req);

    always_comb begin
        idx   = '0;
        vld   = 1'b0;
        sum   = '0;
        cand  = '0;
        grant = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            sum = {1'b0, ptr} + 4'(i);
            if (sum >= NR) sum = sum - NR;
            cand = sum[2:0];
            if (!vld && req_ext[cand]) begin
                vld = 1'b1;
                idx = cand;
            end
        end
        for (int j = 0; j < NUM_REQ; j++) begin
            grant[j] = vld && (idx == 3'(j));
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one UART transmitter among NUM_REQ byte sources.
// Define UART_ARB_TAG_EN to precede every granted byte with tag 8'hA0|grant_id.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int BUSY_TO = 15
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [BYTE_W*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]        ack,
    output logic [2:0]                grant_id,
    output logic                      tx_start,
    output logic [BYTE_W-1:0]         tx_data,
    input  logic                      tx_busy,
    output logic                      tx_timeout
);

    localparam logic [2:0]          LAST_IDX = 3'(NUM_REQ - 1);
    localparam logic [TO_CNT_W-1:0] TO_LAST  = TO_CNT_W'(BUSY_TO - 1);
`ifdef UART_ARB_TAG_EN
    localparam arb_state_t ST_FIRST = ST_TAG_LOAD;
`else
    localparam arb_state_t ST_FIRST = ST_LOAD;
`endif

    arb_state_t          state, state_nxt;
    logic [2:0]          rr_ptr;
    logic [TO_CNT_W-1:0] to_cnt;
    logic [7:0]          req_ext;

    logic [NUM_REQ-1:0]  arb_grant;
    logic [2:0]          arb_idx;
    logic                arb_vld;

    logic [2:0]          sel_idx;
    logic                sel_vld;
    logic [NUM_REQ-1:0]  sel_onehot;
    logic [BYTE_W-1:0]   sel_byte;

    logic                take_grant;
    logic                load_fire;
    logic                tag_fire;
    logic                to_hit;

    assign req_ext = 8'(req);

    rr_arb #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_arb (
        .req   (req),
        .ptr   (rr_ptr),
        .grant (arb_grant),
        .idx   (arb_idx),
        .vld   (arb_vld)
    );

    // Keep the current owner while it still requests; otherwise re-arbitrate on live req.
    always_comb begin
        sel_idx    = arb_idx;
        sel_vld    = arb_vld;
        sel_onehot = arb_grant;
        if (req_ext[grant_id]) begin
            sel_idx = grant_id;
            sel_vld = 1'b1;
            for (int i = 0; i < NUM_REQ; i++) begin
                sel_onehot[i] = (grant_id == 3'(i));
            end
        end
        sel_byte = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (sel_onehot[i]) sel_byte = sel_byte | req_data[BYTE_W*i +: BYTE_W];
        end
    end

    always_comb begin
        state_nxt  = state;
        take_grant = 1'b0;
        load_fire  = 1'b0;
        tag_fire   = 1'b0;
        to_hit     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (arb_vld && !tx_busy) begin
                    take_grant = 1'b1;
                    state_nxt  = ST_FIRST;
                end
            end
`ifdef UART_ARB_TAG_EN
            ST_TAG_LOAD: begin
                if (sel_vld) begin
                    tag_fire  = 1'b1;
                    state_nxt = ST_TAG_HI;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_TAG_HI: begin
                if (tx_busy) begin
                    state_nxt = ST_TAG_LO;
                end else if (to_cnt == TO_LAST) begin
                    to_hit    = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            ST_TAG_LO: begin
                if (!tx_busy) state_nxt = ST_LOAD;
            end
`endif
            ST_LOAD: begin
                if (sel_vld) begin
                    load_fire = 1'b1;
                    state_nxt = ST_WAIT_HI;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_WAIT_HI: begin
                if (tx_busy) begin
                    state_nxt = ST_WAIT_LO;
                end else if (to_cnt == TO_LAST) begin
                    to_hit    = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            ST_WAIT_LO: begin
                if (!tx_busy) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Outputs are registered so tx_data, ack and tx_start change on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            rr_ptr     <= '0;
            grant_id   <= '0;
            tx_start   <= 1'b0;
            ack        <= '0;
            tx_data    <= '0;
            tx_timeout <= 1'b0;
            to_cnt     <= '0;
        end else begin
            state    <= state_nxt;
            tx_start <= load_fire | tag_fire;
            ack      <= load_fire ? sel_onehot : '0;
            if (take_grant) grant_id <= arb_idx;
            if (tag_fire) begin
                grant_id <= sel_idx;
                tx_data  <= UART_TAG_BASE | BYTE_W'(sel_idx);
            end
            if (load_fire) begin
                grant_id <= sel_idx;
                tx_data  <= sel_byte;
                rr_ptr   <= (sel_idx == LAST_IDX) ? 3'd0 : sel_idx + 3'd1;
            end
            if (to_hit) tx_timeout <= 1'b1;
            if (state == ST_WAIT_HI || state == ST_TAG_HI) to_cnt <= to_cnt + TO_CNT_W'(1);
            else                                           to_cnt <= '0;
        end
    end

endmodule
